// File: rtl/alu_cmd_dispatcher.sv
// Command FIFO and issue sequencer feeding the fixed-point ALU; matrix ops go out as one burst.
// Optional watchdog on the completion wait is enabled with `define ALU_DISP_TIMEOUT_EN.
module alu_cmd_dispatcher #(
  parameter int unsigned INST_W    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAT_BEATS = 8
`ifdef ALU_DISP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [INST_W-1:0]          i_cmd_inst,
  input  logic [DATA_W-1:0]          i_cmd_a,
  input  logic [DATA_W-1:0]          i_cmd_b,
  output logic                       o_alu_valid,
  input  logic                       i_alu_busy,
  output logic [INST_W-1:0]          o_alu_inst,
  output logic [DATA_W-1:0]          o_alu_a,
  output logic [DATA_W-1:0]          o_alu_b,
  input  logic                       i_alu_out_valid,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_idle,
  output logic                       o_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(MAT_BEATS + 1);
  localparam logic [INST_W-1:0] MAT_INST = INST_W'(9);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [DATA_W-1:0] r_mem_a    [DEPTH];
  logic [DATA_W-1:0] r_mem_b    [DEPTH];

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_cmd_ready;
  logic              r_idle;
  logic [1:0]        r_state;
  logic [CW-1:0]     r_beat_cnt;
  logic              r_seen_ov;
  logic              r_alu_valid;
  logic [INST_W-1:0] r_alu_inst;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_head_mat;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_seen_nxt;
  logic [LW-1:0]     w_level_nxt;

`ifdef ALU_DISP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0]     r_wait_cnt;
  logic              r_timeout;
  logic              w_timeout_set;
`endif

  assign w_push     = i_cmd_valid && r_cmd_ready;
  assign w_empty    = (r_level == '0);
  assign w_head_mat = (r_mem_inst[r_rd_ptr] == MAT_INST);

  // Issue sequencing: single beats from S_IDLE, matrix groups only once fully buffered
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cnt_nxt   = r_beat_cnt;
    w_seen_nxt  = r_seen_ov;
`ifdef ALU_DISP_TIMEOUT_EN
    w_timeout_set = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !i_alu_busy) begin
          if (!w_head_mat) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WAIT;
          end else if (r_level >= LW'(MAT_BEATS)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        w_pop     = 1'b1;
        w_cnt_nxt = r_beat_cnt + CW'(1);
        if (r_beat_cnt == CW'(MAT_BEATS - 1)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_alu_out_valid) begin
          w_seen_nxt = 1'b1;
        end
        if (r_seen_ov && !i_alu_busy) begin
          w_seen_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
`ifdef ALU_DISP_TIMEOUT_EN
        else if (r_wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
          w_seen_nxt    = 1'b0;
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and level
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= i_cmd_inst;
      r_mem_a[r_wr_ptr]    <= i_cmd_a;
      r_mem_b[r_wr_ptr]    <= i_cmd_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_seen_ov   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cmd_ready <= 1'b1;
      r_idle      <= 1'b1;
      r_alu_valid <= 1'b0;
      r_alu_inst  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_seen_ov   <= w_seen_nxt;
      r_level     <= w_level_nxt;
      r_cmd_ready <= (w_level_nxt != LW'(DEPTH));
      r_idle      <= (w_level_nxt == '0) && (w_state_nxt == S_IDLE);
      r_alu_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_alu_inst <= r_mem_inst[r_rd_ptr];
        r_alu_a    <= r_mem_a[r_rd_ptr];
        r_alu_b    <= r_mem_b[r_rd_ptr];
      end
    end
  end

`ifdef ALU_DISP_TIMEOUT_EN
  // Watchdog counts consecutive cycles spent waiting for completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_WAIT && w_state_nxt == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + TW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_cmd_ready = r_cmd_ready;
  assign o_alu_valid = r_alu_valid;
  assign o_alu_inst  = r_alu_inst;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_level     = r_level;
  assign o_idle      = r_idle;

endmodule
